// File: rtl/sinfonia_pkg.sv
// sinfonia_pkg: shared definitions for the buzzer scheduler.
//   estado_t : FSM state encoding (OCIOSO=0, TOCA=1, PAUSA=2, ERRO=3)
//   dono_t   : which requester owns the note being played
//   SILENCIO : buzzer code for silence
//   max3     : helper used to size the shared note/gap/error timer
package sinfonia_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    TOCA   = 2'd1,
    PAUSA  = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  typedef enum logic {
    DONO_BOTAO  = 1'b0,
    DONO_MUSICA = 1'b1
  } dono_t;

  localparam logic [2:0] SILENCIO = 3'b000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/timer_nota.sv
// timer_nota: up-counter shared by all timed states.
//   clock, reset : clock and asynchronous active-high reset
//   clr          : synchronous clear (dominates en)
//   en           : count enable
//   limite       : length of the current interval in cycles (>=1)
//   fim          : terminal count, high while the count equals limite-1
module timer_nota #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] cont;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cont <= '0;
    else if (clr) cont <= '0;
    else if (en)  cont <= cont + 1'b1;
  end

  assign fim = (cont == limite - W'(1));

endmodule

// File: rtl/escalonador_buzzer.sv
// escalonador_buzzer: arbitrates the 3-bit buzzer bus between the error
// tone (highest priority, preempts), button feedback and melody playback.
//   clock, reset                 : clock, asynchronous active-high reset
//   req_erro/req_botao/req_musica: level-held requests
//   nota_botao/nota_musica       : note codes, sampled at grant
//   grant_*, done_*              : one-cycle grant / completion pulses
//   abortado                     : with done_botao/done_musica when preempted
//   ocupado                      : high outside OCIOSO
//   arduino_out                  : registered buzzer code (000 = silence)
//   db_estado                    : current state encoding
module escalonador_buzzer
  import sinfonia_pkg::*;
#(
  parameter int         DUR_NOTA  = 25_000_000,
  parameter int         GAP       = 2_500_000,
  parameter int         DUR_ERRO  = 50_000_000,
  parameter logic [2:0] NOTA_ERRO = 3'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_erro,
  input  logic       req_botao,
  input  logic [2:0] nota_botao,
  input  logic       req_musica,
  input  logic [2:0] nota_musica,
  output logic       grant_erro,
  output logic       grant_botao,
  output logic       grant_musica,
  output logic       done_erro,
  output logic       done_botao,
  output logic       done_musica,
  output logic       abortado,
  output logic       ocupado,
  output logic [2:0] arduino_out,
  output logic [2:0] db_estado
);

  localparam int W = $clog2(max3(DUR_NOTA, GAP, DUR_ERRO) + 1);

  estado_t        estado;
  dono_t          dono;
  logic [W-1:0]   limite;
  logic           fim;
  logic           clr;

  // Interval length for the state being timed; OCIOSO keeps the timer cleared.
  always_comb begin
    limite = W'(1);
    clr    = 1'b0;
    case (estado)
      OCIOSO: clr = 1'b1;
      TOCA:   begin limite = W'(DUR_NOTA); clr = fim | req_erro; end
      PAUSA:  begin limite = W'(GAP);      clr = fim | req_erro; end
      ERRO:   begin limite = W'(DUR_ERRO); clr = fim;            end
      default: clr = 1'b1;
    endcase
  end

  timer_nota #(.W(W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .en     (1'b1),
    .limite (limite),
    .fim    (fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      dono         <= DONO_BOTAO;
      arduino_out  <= SILENCIO;
      grant_erro   <= 1'b0;
      grant_botao  <= 1'b0;
      grant_musica <= 1'b0;
      done_erro    <= 1'b0;
      done_botao   <= 1'b0;
      done_musica  <= 1'b0;
      abortado     <= 1'b0;
    end else begin
      grant_erro   <= 1'b0;
      grant_botao  <= 1'b0;
      grant_musica <= 1'b0;
      done_erro    <= 1'b0;
      done_botao   <= 1'b0;
      done_musica  <= 1'b0;
      abortado     <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (req_erro) begin
            estado      <= ERRO;
            grant_erro  <= 1'b1;
            arduino_out <= NOTA_ERRO;
          end else if (req_botao) begin
            estado      <= TOCA;
            dono        <= DONO_BOTAO;
            grant_botao <= 1'b1;
            arduino_out <= nota_botao;   // output register doubles as note latch
          end else if (req_musica) begin
            estado       <= TOCA;
            dono         <= DONO_MUSICA;
            grant_musica <= 1'b1;
            arduino_out  <= nota_musica;
          end
        end
        TOCA, PAUSA: begin
          if (req_erro) begin
            // Preemption wins even on the last cycle of a note or gap.
            estado      <= ERRO;
            grant_erro  <= 1'b1;
            abortado    <= 1'b1;
            done_botao  <= (dono == DONO_BOTAO);
            done_musica <= (dono == DONO_MUSICA);
            arduino_out <= NOTA_ERRO;
          end else if (fim) begin
            if (estado == TOCA) begin
              estado      <= PAUSA;
              arduino_out <= SILENCIO;
            end else begin
              estado      <= OCIOSO;
              done_botao  <= (dono == DONO_BOTAO);
              done_musica <= (dono == DONO_MUSICA);
            end
          end
        end
        ERRO: begin
          if (fim) begin
            estado      <= OCIOSO;
            done_erro   <= 1'b1;
            arduino_out <= SILENCIO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign ocupado   = (estado != OCIOSO);
  assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_escalonador_buzzer.sv
// Bench for escalonador_buzzer with DUR_NOTA=4, GAP=2, DUR_ERRO=6, NOTA_ERRO=1.
// A schedule model expands each granted request into its full per-cycle
// output sequence; a compare process checks every cycle out of reset.
module tb_escalonador_buzzer;

  localparam int         DN = 4;
  localparam int         GP = 2;
  localparam int         DE = 6;
  localparam logic [2:0] NE = 3'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_erro = 1'b0, req_botao = 1'b0, req_musica = 1'b0;
  logic [2:0] nota_botao = 3'd0, nota_musica = 3'd0;
  logic       grant_erro, grant_botao, grant_musica;
  logic       done_erro, done_botao, done_musica;
  logic       abortado, ocupado;
  logic [2:0] arduino_out, db_estado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  escalonador_buzzer #(.DUR_NOTA(DN), .GAP(GP), .DUR_ERRO(DE), .NOTA_ERRO(NE)) dut (
    .clock(clk), .reset(rst),
    .req_erro(req_erro), .req_botao(req_botao), .nota_botao(nota_botao),
    .req_musica(req_musica), .nota_musica(nota_musica),
    .grant_erro(grant_erro), .grant_botao(grant_botao), .grant_musica(grant_musica),
    .done_erro(done_erro), .done_botao(done_botao), .done_musica(done_musica),
    .abortado(abortado), .ocupado(ocupado),
    .arduino_out(arduino_out), .db_estado(db_estado)
  );

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- schedule model ----------------
  // gnt/dn bit order: {erro, botao, musica}
  typedef struct packed {
    logic [2:0] ard;
    logic [2:0] gnt;
    logic [2:0] dn;
    logic       ab;
    logic       oc;
    logic [2:0] st;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  logic dono_botao_m = 1'b0;

  task automatic push_nota(input logic botao, input logic [2:0] n);
    exp_t e;
    for (int i = 0; i < DN; i++) begin
      e = '0; e.ard = n; e.oc = 1'b1; e.st = 3'd1;
      if (i == 0) e.gnt = botao ? 3'b010 : 3'b001;
      q.push_back(e);
    end
    for (int i = 0; i < GP; i++) begin
      e = '0; e.oc = 1'b1; e.st = 3'd2;
      q.push_back(e);
    end
    e = '0; e.dn = botao ? 3'b010 : 3'b001;
    q.push_back(e);
  endtask

  task automatic push_erro(input logic [2:0] abort_dn);
    exp_t e;
    for (int i = 0; i < DE; i++) begin
      e = '0; e.ard = NE; e.oc = 1'b1; e.st = 3'd3;
      if (i == 0) begin e.gnt = 3'b100; e.dn = abort_dn; e.ab = |abort_dn; end
      q.push_back(e);
    end
    e = '0; e.dn = 3'b100;
    q.push_back(e);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur = '0;
    end else begin
      if (cur.st == 3'd0) begin
        if (req_erro)        push_erro(3'b000);
        else if (req_botao)  begin dono_botao_m = 1'b1; push_nota(1'b1, nota_botao); end
        else if (req_musica) begin dono_botao_m = 1'b0; push_nota(1'b0, nota_musica); end
      end else if ((cur.st == 3'd1 || cur.st == 3'd2) && req_erro) begin
        q.delete();
        push_erro(dono_botao_m ? 3'b010 : 3'b001);
      end
      cur = (q.size() > 0) ? q.pop_front() : '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    exp_t d;
    if (!rst) begin
      d = '0;
      d.ard = arduino_out;
      d.gnt = {grant_erro, grant_botao, grant_musica};
      d.dn  = {done_erro, done_botao, done_musica};
      d.ab  = abortado;
      d.oc  = ocupado;
      d.st  = db_estado;
      checks++;
      if (d !== cur) begin
        errors++;
        $display("FAIL cycle t=%0t got ard=%0d gnt=%b dn=%b ab=%b oc=%b st=%0d want ard=%0d gnt=%b dn=%b ab=%b oc=%b st=%0d",
                 $time, d.ard, d.gnt, d.dn, d.ab, d.oc, d.st,
                 cur.ard, cur.gnt, cur.dn, cur.ab, cur.oc, cur.st);
      end
    end
  end

  // ---------------- stimulus ----------------
  // which: 0 grant_erro, 1 grant_botao, 2 grant_musica, 3 done_erro, 4 done_botao, 5 done_musica
  task automatic wait_sig(input int which, input string name, output int n);
    logic s;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      case (which)
        0: s = grant_erro;   1: s = grant_botao; 2: s = grant_musica;
        3: s = done_erro;    4: s = done_botao;  default: s = done_musica;
      endcase
      if (s) begin n = i; return; end
    end
    chk({name, "_timeout"}, 0, 1);
    n = -1;
  endtask

  initial begin
    int n, notes, silent, done_at, ab_seen;

    #1;
    chk("reset_ard", arduino_out, 0);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_grants", {grant_erro, grant_botao, grant_musica}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the 2nd note cycle of a botao note: immediate silence, no done.
    req_botao = 1'b1; nota_botao = 3'd5;
    wait_sig(1, "t1_grant", n);
    chk("t1_grant_lat", n, 1);
    chk("t1_first_note", arduino_out, 5);
    req_botao = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_ard", arduino_out, 0);
    chk("t1_rst_ocupado", ocupado, 0);
    chk("t1_rst_done", done_botao, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);   // model expects idle: no late done_botao

    // Single musica note 3.
    req_musica = 1'b1; nota_musica = 3'd3;
    wait_sig(2, "t2_grant", n);
    chk("t2_grant_lat", n, 1);
    req_musica = 1'b0; nota_musica = 3'd6;   // later note changes must not matter
    notes = 0; silent = 0; done_at = -1; ab_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (arduino_out == 3'd3) notes++;
      if (ocupado && arduino_out == 3'd0) silent++;
      if (done_musica) done_at = i;
      if (abortado) ab_seen++;
      @(negedge clk);
    end
    chk("t2_note_cycles", notes, DN);
    chk("t2_gap_cycles", silent, GP);
    chk("t2_done_offset", done_at, DN + GP);
    chk("t2_abortado", ab_seen, 0);

    // All three requests at once: erro, then botao, then musica.
    nota_botao = 3'd4; nota_musica = 3'd2;
    req_erro = 1'b1; req_botao = 1'b1; req_musica = 1'b1;
    wait_sig(0, "t3_gerro", n);
    chk("t3_erro_first", {grant_botao, grant_musica}, 0);
    chk("t3_erro_tone", arduino_out, NE);
    req_erro = 1'b0;
    wait_sig(1, "t3_gbotao", n);
    chk("t3_botao_after", n, DE + 1);
    req_botao = 1'b0;
    wait_sig(2, "t3_gmusica", n);
    chk("t3_musica_after", n, DN + GP + 1);
    req_musica = 1'b0;
    wait_sig(5, "t3_dmusica", n);
    repeat (2) @(negedge clk);

    // Preempt botao note 7 in its 2nd note cycle.
    req_botao = 1'b1; nota_botao = 3'd7;
    wait_sig(1, "t4_grant", n);
    req_botao = 1'b0;
    @(negedge clk);
    req_erro = 1'b1;
    @(negedge clk);
    chk("t4_ard", arduino_out, NE);
    chk("t4_pulses", {grant_erro, done_botao, abortado}, 3'b111);
    req_erro = 1'b0;
    wait_sig(3, "t4_derro", n);
    chk("t4_erro_len", n, DE);
    repeat (2) @(negedge clk);

    // Musica rest note: silent but busy for DN+GP cycles.
    req_musica = 1'b1; nota_musica = 3'd0;
    wait_sig(2, "t5_grant", n);
    req_musica = 1'b0;
    silent = 0; done_at = -1;
    for (int i = 0; i < 9; i++) begin
      if (ocupado && arduino_out == 3'd0) silent++;
      if (done_musica) done_at = i;
      @(negedge clk);
    end
    chk("t5_silent_busy", silent, DN + GP);
    chk("t5_done_offset", done_at, DN + GP);

    // botao request during musica PAUSA waits for done_musica.
    req_musica = 1'b1; nota_musica = 3'd2;
    wait_sig(2, "t6_grant", n);
    req_musica = 1'b0;
    repeat (DN) @(negedge clk);
    chk("t6_in_pausa", db_estado, 2);
    req_botao = 1'b1; nota_botao = 3'd6;
    wait_sig(1, "t6_gbotao", n);
    chk("t6_botao_lat", n, GP + 1);
    req_botao = 1'b0;
    wait_sig(4, "t6_dbotao", n);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escalonador_buzzer.md
# escalonador_buzzer

Arbitrates and sequences the 3-bit buzzer bus `arduino_out` between three requesters: the error tone, button-press feedback and melody playback. It sits between the control unit / datapath and the Arduino pin. It times each note with a fixed duration followed by a silent gap. The error tone has priority and preempts an active note.

## Interface
Parameters:
- `DUR_NOTA`, default 25_000_000: cycles a botao/musica note sounds (≥1).
- `GAP`, default 2_500_000: silent cycles after a botao/musica note (≥1).
- `DUR_ERRO`, default 50_000_000: cycles the error tone sounds (≥1).
- `NOTA_ERRO`, default 3'd1: code driven during the error tone.

Ports:
- `clock` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-high.
- `req_erro` in 1: error-tone request, level-held until `grant_erro`.
- `req_botao` in 1: feedback request, level-held until `grant_botao`.
- `nota_botao` in 3: note code for botao, sampled at grant.
- `req_musica` in 1: playback request, level-held until `grant_musica`.
- `nota_musica` in 3: note code for musica, sampled at grant; 3'b000 = rest.
- `grant_erro`, `grant_botao`, `grant_musica` out 1 each: one-cycle grant pulses.
- `done_erro`, `done_botao`, `done_musica` out 1 each: one-cycle completion pulses.
- `abortado` out 1: pulses with `done_botao`/`done_musica` when that note was preempted.
- `ocupado` out 1: high in any state except OCIOSO.
- `arduino_out` out 3: buzzer code; 3'b000 = silence.
- `db_estado` out 3: current state encoding.

## Operation
- States: OCIOSO, TOCA, PAUSA, ERRO. The owner register (botao/musica) is valid in TOCA and PAUSA.
- OCIOSO: at an edge with any request high, fixed priority applies: erro > botao > musica.
  - erro → ERRO.
  - botao or musica → TOCA; owner latched; note latched from `nota_*`.
  - The timer clears on entry.
- TOCA: `arduino_out` = latched note. After DUR_NOTA cycles → PAUSA.
- PAUSA: `arduino_out` = 000. After GAP cycles → OCIOSO with `done_<owner>`.
- ERRO: `arduino_out` = NOTA_ERRO. After DUR_ERRO cycles → OCIOSO with `done_erro`. Requests are ignored in ERRO.
- Preemption: `req_erro` high in TOCA or PAUSA:
  - The next state is ERRO.
  - In the same cycle, `done_<owner>` and `abortado` pulse and `grant_erro` pulses.
- botao never preempts musica. A request pending while busy waits, level-held, and is evaluated in OCIOSO.
- A latched note of 000 is a timed rest: silent for DUR_NOTA, then GAP. This is not an error.
- Input note changes after grant have no effect.
- Reset, including mid-note, forces OCIOSO; all outputs and registers go to 0 (`arduino_out` = 000). No done pulse is emitted.

## Timing
- Request seen at edge k:
  - the grant pulse and first note cycle occur in cycle k+1;
  - `arduino_out` is registered, with no combinational path from inputs.
- TOCA lasts exactly DUR_NOTA cycles and PAUSA exactly GAP cycles.
- The done pulse occurs in the first OCIOSO cycle. The earliest next grant is the cycle after done, so requests are back-to-back with one idle cycle.
- ERRO lasts exactly DUR_ERRO cycles; `done_erro` timing follows the same rule.
- Preemption: `req_erro` seen at edge k → cycle k+1 carries NOTA_ERRO, `grant_erro`, `done_<owner>` and `abortado`.
- Timer:
  - width = $clog2(max(DUR_NOTA, GAP, DUR_ERRO)+1);
  - counts 0..limit-1;
  - terminal count is compared at limit-1, then the timer clears.
- Simultaneous requests in OCIOSO: only the highest is granted; the others keep waiting.

## Structure
- Shared package `sinfonia_pkg`:
  - state encoding (OCIOSO=0, TOCA=1, PAUSA=2, ERRO=3);
  - owner IDs;
  - `SILENCIO` = 3'b000.
- One sub-module, `timer_nota`: a parameterised up-counter with clear, enable and terminal-count output.
- The FSM, arbitration and output registers are in the top level.

## Test plan
Bench parameters: DUR_NOTA=4, GAP=2, DUR_ERRO=6, NOTA_ERRO=1.
- Reset mid-TOCA (`req_botao`, note 5, reset asserted in the 2nd note cycle) → `arduino_out` = 000, `ocupado` = 0 immediately; no `done_botao`.
- Single `req_musica`, note 3 → `grant_musica` 1 cycle; `arduino_out` = 3 for 4 cycles, then 000 for 2 cycles; `done_musica` in the next cycle; `abortado` = 0.
- `req_erro`, `req_botao` and `req_musica` high together in OCIOSO → erro granted, tone 1 for 6 cycles; then botao granted one cycle after `done_erro`; then musica.
- `req_erro` during the 2nd TOCA cycle of botao note 7 → next cycle `arduino_out` = 1 with `grant_erro`, `done_botao` and `abortado` all high; 6 error cycles follow.
- musica note 000 → 6 silent cycles with `ocupado` = 1, then `done_musica`.
- `req_botao` asserted during musica PAUSA → not granted until after `done_musica`; granted in the following cycle.
